// File: rtl/issue_interlock_ctrl.sv
// Issue-stage interlock: per-register write scoreboard, branch-shadow hold and sticky halt.
// Decides each cycle whether the instruction in IF/ID moves to ID/EX or is held with a bubble.
module issue_interlock_ctrl #(
  parameter int unsigned WB_LAT = 3,
  parameter int unsigned BR_LAT = 2
) (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  output logic        issue,
  output logic        stall,
  output logic        halted,
  output logic [31:0] busy_mask,
  output logic [15:0] stall_cnt
);

  localparam logic [2:0] WbLat = 3'(WB_LAT);
  localparam logic [2:0] BrLat = 3'(BR_LAT);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StBrWait = 2'd1,
    StHalt   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  br_cnt_q, br_cnt_d;
  logic [2:0]  cnt_q [32];
  logic [2:0]  cnt_d [32];
  logic [31:0] busy_q, busy_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Instruction fields
  logic [5:0] opcode;
  logic [4:0] rs, rt, rd;
  logic       use_rs, use_rt, dest_en, is_branch, is_halt;
  logic [4:0] dest;
  logic       hazard;
  logic       unused_imm;

  assign opcode     = id_instr[31:26];
  assign rs         = id_instr[25:21];
  assign rt         = id_instr[20:16];
  assign rd         = id_instr[15:11];
  assign unused_imm = ^id_instr[10:0];

  always_comb begin
    use_rs    = 1'b0;
    use_rt    = 1'b0;
    dest_en   = 1'b0;
    dest      = rd;
    is_branch = 1'b0;
    is_halt   = 1'b0;
    unique case (opcode)
      6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5: begin
        use_rs  = 1'b1;
        use_rt  = 1'b1;
        dest_en = 1'b1;
        dest    = rd;
      end
      6'd8, 6'd10, 6'd11, 6'd12: begin
        use_rs  = 1'b1;
        dest_en = 1'b1;
        dest    = rt;
      end
      6'd9: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      6'd13, 6'd14: begin
        use_rs    = 1'b1;
        is_branch = 1'b1;
      end
      6'd63: is_halt = 1'b1;
      default: ;
    endcase
  end

  // Counts are checked before this cycle's update, so a self-dependent op sees its old state.
  assign hazard = (use_rs && (cnt_q[rs] != 3'd0)) || (use_rt && (cnt_q[rt] != 3'd0));
  assign stall  = id_valid && (hazard || (state_q != StRun));
  assign issue  = id_valid && !stall;

  always_comb begin
    for (int r = 0; r < 32; r++) begin
      cnt_d[r] = (cnt_q[r] != 3'd0) ? cnt_q[r] - 3'd1 : 3'd0;
    end
    if (issue && dest_en && (dest != 5'd0)) begin
      cnt_d[dest] = WbLat;
    end
    cnt_d[0] = 3'd0;
    for (int r = 0; r < 32; r++) begin
      busy_d[r] = (cnt_d[r] != 3'd0);
    end
  end

  always_comb begin
    state_d  = state_q;
    br_cnt_d = br_cnt_q;
    unique case (state_q)
      StRun: begin
        if (issue && is_branch) begin
          state_d  = StBrWait;
          br_cnt_d = BrLat;
        end else if (issue && is_halt) begin
          state_d = StHalt;
        end
      end
      StBrWait: begin
        if (br_cnt_q <= 3'd1) begin
          state_d  = StRun;
          br_cnt_d = 3'd0;
        end else begin
          br_cnt_d = br_cnt_q - 3'd1;
        end
      end
      StHalt: ;
      default: begin
        state_d  = StRun;
        br_cnt_d = 3'd0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q     <= StRun;
      br_cnt_q    <= 3'd0;
      busy_q      <= 32'd0;
      stall_cnt_q <= 16'd0;
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= 3'd0;
      end
    end else begin
      state_q     <= state_d;
      br_cnt_q    <= br_cnt_d;
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  assign halted    = (state_q == StHalt);
  assign busy_mask = busy_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_issue_interlock_ctrl.sv
// Bench for issue_interlock_ctrl: timestamp-based model checked every cycle, plus directed
// instruction sequences with hand-computed stall counts and output values.
module tb_issue_interlock_ctrl;

  localparam int WB_LAT = 3;
  localparam int BR_LAT = 2;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_instr;
  logic        issue, stall, halted;
  logic [31:0] busy_mask;
  logic [15:0] stall_cnt;

  issue_interlock_ctrl #(
    .WB_LAT(WB_LAT),
    .BR_LAT(BR_LAT)
  ) dut (
    .clk1     (clk1),
    .rst_n    (rst_n),
    .id_valid (id_valid),
    .id_instr (id_instr),
    .issue    (issue),
    .stall    (stall),
    .halted   (halted),
    .busy_mask(busy_mask),
    .stall_cnt(stall_cnt)
  );

  always #5 clk1 = ~clk1;

  int errors = 0;
  int checks = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
    end
  endfunction

  // Model: a register is busy while the cycle number is before its ready time;
  // issue is blocked while the cycle number is before hold_until or after halt.
  int ready [32];
  int hold_until = 0;
  int cyc = 0;
  int scnt = 0;
  bit halted_m = 0;
  bit model_ok = 0;

  function automatic void decode(input logic [31:0] ins, output bit ur, output bit ut,
                                 output int dst, output bit br, output bit hlt);
    int op;
    op  = int'(ins[31:26]);
    ur  = 0;
    ut  = 0;
    dst = 0;
    br  = 0;
    hlt = 0;
    if (op <= 5) begin
      ur = 1; ut = 1; dst = int'(ins[15:11]);
    end else if (op == 8 || (op >= 10 && op <= 12)) begin
      ur = 1; dst = int'(ins[20:16]);
    end else if (op == 9) begin
      ur = 1; ut = 1;
    end else if (op == 13 || op == 14) begin
      ur = 1; br = 1;
    end else if (op == 63) begin
      hlt = 1;
    end
  endfunction

  function automatic bit reg_busy(input int r);
    return (r != 0) && (ready[r] > cyc);
  endfunction

  function automatic void model_eval(output bit e_issue, output bit e_stall);
    bit ur, ut, br, hlt, hz;
    int dst;
    decode(id_instr, ur, ut, dst, br, hlt);
    hz = (ur && reg_busy(int'(id_instr[25:21]))) || (ut && reg_busy(int'(id_instr[20:16])));
    e_stall = id_valid && (hz || halted_m || (cyc < hold_until));
    e_issue = id_valid && !e_stall;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] m;
    m = '0;
    for (int r = 1; r < 32; r++) m[r] = reg_busy(r);
    return m;
  endfunction

  always @(posedge clk1) begin
    bit e_issue, e_stall, ur, ut, br, hlt;
    int dst;
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) ready[r] = 0;
      hold_until = 0;
      halted_m   = 0;
      scnt       = 0;
      model_ok   = 1;
    end else if (model_ok) begin
      model_eval(e_issue, e_stall);
      decode(id_instr, ur, ut, dst, br, hlt);
      if (e_stall && scnt < 65535) scnt++;
      if (e_issue) begin
        if (dst != 0) ready[dst] = cyc + 1 + WB_LAT;
        if (br) hold_until = cyc + BR_LAT + 1;
        if (hlt) halted_m = 1;
      end
    end
    cyc++;
  end

  always @(negedge clk1) begin
    bit e_issue, e_stall;
    if (model_ok) begin
      model_eval(e_issue, e_stall);
      check("model issue", 32'(issue), 32'(e_issue));
      check("model stall", 32'(stall), 32'(e_stall));
      check("model halted", 32'(halted), 32'(halted_m));
      check("model busy_mask", busy_mask, model_busy());
      check("model stall_cnt", 32'(stall_cnt), 32'(scnt));
    end
  end

  // Present an instruction and hold it until it issues; n = cycles spent stalled.
  task automatic present(input logic [31:0] ins, output int n);
    @(posedge clk1);
    #1;
    id_valid = 1'b1;
    id_instr = ins;
    n = 0;
    @(negedge clk1);
    while (!issue && n < 20) begin
      n++;
      @(negedge clk1);
    end
    if (!issue) check("issue timeout", 32'(issue), 32'd1);
  endtask

  task automatic pulse_reset();
    @(posedge clk1);
    #1;
    rst_n    = 1'b0;
    id_valid = 1'b0;
    @(posedge clk1);
    #1;
    rst_n = 1'b1;
  endtask

  int n;

  initial begin
    rst_n    = 1'b0;
    id_valid = 1'b0;
    id_instr = 32'd0;
    repeat (2) @(posedge clk1);
    #1;
    rst_n = 1'b1;
    @(negedge clk1);
    check("reset busy_mask", busy_mask, 32'd0);
    check("reset stall_cnt", 32'(stall_cnt), 32'd0);

    // ADDI R1,R0,10 issues at once; then ADDI R2 sees R1 marked
    present(32'h2801000a, n);
    check("addi r1 stalls", 32'(n), 32'd0);
    present(32'h28020005, n);
    check("addi r2 stalls", 32'(n), 32'd0);
    check("busy after addi r1", busy_mask, 32'h0000_0002);
    // ADD R4,R1,R2 back-to-back on R2: WB_LAT stall cycles
    present(32'h00222000, n);
    check("add r4 stalls", 32'(n), 32'd3);
    check("stall_cnt after add", 32'(stall_cnt), 32'd3);

    // R0-only sources never block, rd=R0 is never marked
    present(32'h00002800, n);
    check("add r5 r0 r0 stalls", 32'(n), 32'd0);
    present(32'h0c003800, n);
    check("or r7 r0 r0 stalls", 32'(n), 32'd0);
    present(32'h00000000, n);
    check("add r0 stalls", 32'(n), 32'd0);

    @(posedge clk1);
    #1;
    id_valid = 1'b0;
    @(negedge clk1);
    check("idle stall", 32'(stall), 32'd0);
    check("idle issue", 32'(issue), 32'd0);

    // BEQZ R3 then ADDI R6: BR_LAT shadow cycles
    present(32'h38600000, n);
    check("beqz r3 stalls", 32'(n), 32'd0);
    present(32'h28060001, n);
    check("after branch stalls", 32'(n), 32'd2);

    // HLT with R4 pending
    present(32'h28040001, n);
    present(32'hfc000000, n);
    check("hlt stalls", 32'(n), 32'd0);
    @(posedge clk1);
    #1;
    id_instr = 32'h00002800;
    @(negedge clk1);
    check("halted", 32'(halted), 32'd1);
    check("halt stall valid", 32'(stall), 32'd1);
    @(posedge clk1);
    #1;
    id_valid = 1'b0;
    @(negedge clk1);
    check("halt stall idle", 32'(stall), 32'd0);
    @(negedge clk1);
    check("halt busy drained", busy_mask, 32'd0);

    // Build up BR_WAIT with R4 pending and stall_cnt=5, then reset
    pulse_reset();
    present(32'h38000000, n);
    present(32'h38000000, n);
    check("branch after branch", 32'(n), 32'd2);
    present(32'h28040001, n);
    present(32'h38000000, n);
    @(posedge clk1);
    #1;
    id_instr = 32'h28060001;
    @(negedge clk1);
    @(negedge clk1);
    check("pre-reset stall", 32'(stall), 32'd1);
    check("pre-reset busy", busy_mask, 32'h0000_0010);
    check("pre-reset stall_cnt", 32'(stall_cnt), 32'd5);
    #1;
    rst_n = 1'b0;
    @(posedge clk1);
    #1;
    rst_n = 1'b1;
    @(negedge clk1);
    check("post-reset issue", 32'(issue), 32'd1);
    check("post-reset stall", 32'(stall), 32'd0);
    check("post-reset busy", busy_mask, 32'd0);
    check("post-reset stall_cnt", 32'(stall_cnt), 32'd0);
    check("post-reset halted", 32'(halted), 32'd0);

    @(posedge clk1);
    #1;
    id_valid = 1'b0;
    repeat (3) @(negedge clk1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
